// File: rtl/arbiter_pred_wrr_pkg.sv
// rtl/arbiter_pred_wrr_pkg.sv - shared state encoding for the predictive weighted round-robin arbiter
package arbiter_pred_wrr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_PARK  = 2'd2
    } state_t;

endpackage

// File: rtl/arbiter_pred_wrr_priority_encoder.sv
// rtl/arbiter_pred_wrr_priority_encoder.sv - priority encoder with selectable LSB/MSB priority
module arbiter_pred_wrr_priority_encoder #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]         unencoded,
    output logic                     valid,
    output logic [$clog2(WIDTH)-1:0] encoded,
    output logic [WIDTH-1:0]         one_hot
);

    localparam int ENC_W = $clog2(WIDTH);

    always_comb begin
        valid   = |unencoded;
        encoded = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (unencoded[i]) encoded = ENC_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (unencoded[i]) encoded = ENC_W'(i);
            end
        end
        one_hot = valid ? (WIDTH'(1) << encoded) : '0;
    end

endmodule

// File: rtl/arbiter_pred_wrr.sv
// rtl/arbiter_pred_wrr.sv - ack-blocking weighted round-robin arbiter with parked grant prediction
module arbiter_pred_wrr
    import arbiter_pred_wrr_pkg::*;
#(
    parameter int PORTS                 = 4,
    parameter int WEIGHT_WIDTH          = 4,
    parameter int ARB_LSB_HIGH_PRIORITY = 0,
    parameter int PARK_ENABLE           = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              request,
    input  logic [PORTS-1:0]              acknowledge,
    input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
    output logic [PORTS-1:0]              grant,
    output logic                          grant_valid,
    output logic [$clog2(PORTS)-1:0]      grant_encoded,
    output logic                          pred_hit,
    output logic [WEIGHT_WIDTH-1:0]       credit
);

    localparam int ENC_W = $clog2(PORTS);
    localparam logic [WEIGHT_WIDTH-1:0] ONE = WEIGHT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [PORTS-1:0]        grant_q, grant_d;
    logic [ENC_W-1:0]        enc_q, enc_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic [PORTS-1:0]        mask_q, mask_d;
    logic                    valid_q, valid_d;
    logic                    hit_q, hit_d;

    logic [PORTS-1:0]        arb_req;
    logic                    all_valid, msk_valid, win_valid;
    logic [ENC_W-1:0]        all_enc, msk_enc, win_enc;
    logic [PORTS-1:0]        all_oh, msk_oh, win_oh, win_mask;
    logic [WEIGHT_WIDTH-1:0] weight_eff [PORTS];
    logic                    do_win;

    // The released port is excluded so that other requesters win over a self-reload.
    assign arb_req = (state_q == ST_GRANT) ? (request & ~grant_q) : request;

    arbiter_pred_wrr_priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_all (
        .unencoded (arb_req),
        .valid     (all_valid),
        .encoded   (all_enc),
        .one_hot   (all_oh)
    );

    arbiter_pred_wrr_priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_mask (
        .unencoded (arb_req & mask_q),
        .valid     (msk_valid),
        .encoded   (msk_enc),
        .one_hot   (msk_oh)
    );

    assign win_valid = all_valid;
    assign win_enc   = msk_valid ? msk_enc : all_enc;
    assign win_oh    = msk_valid ? msk_oh  : all_oh;

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            weight_eff[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            if (weight_eff[i] == '0) weight_eff[i] = ONE;
            win_mask[i] = (ARB_LSB_HIGH_PRIORITY != 0) ? (i > int'(win_enc)) : (i < int'(win_enc));
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        enc_d    = enc_q;
        credit_d = credit_q;
        mask_d   = mask_q;
        valid_d  = valid_q;
        hit_d    = 1'b0;
        do_win   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) do_win = 1'b1;
            end
            ST_GRANT: begin
                if (|(grant_q & acknowledge)) begin
                    if (credit_q > ONE && |(grant_q & request)) begin
                        credit_d = credit_q - ONE;
                    end else if (win_valid) begin
                        do_win = 1'b1;
                    end else if (|(grant_q & request)) begin
                        credit_d = weight_eff[enc_q];
                    end else begin
                        valid_d  = 1'b0;
                        credit_d = '0;
                        if (PARK_ENABLE != 0) begin
                            state_d = ST_PARK;
                        end else begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                            enc_d   = '0;
                        end
                    end
                end
            end
            ST_PARK: begin
                // Sole requester is the parked port: confirm the prediction, mask untouched.
                if (request == grant_q) begin
                    state_d  = ST_GRANT;
                    valid_d  = 1'b1;
                    credit_d = weight_eff[enc_q];
                    hit_d    = 1'b1;
                end else if (|request) begin
                    do_win = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                enc_d   = '0;
                valid_d = 1'b0;
            end
        endcase
        if (do_win) begin
            state_d  = ST_GRANT;
            valid_d  = 1'b1;
            grant_d  = win_oh;
            enc_d    = win_enc;
            credit_d = weight_eff[win_enc];
            mask_d   = win_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            enc_q    <= '0;
            credit_q <= '0;
            mask_q   <= '0;
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            enc_q    <= enc_d;
            credit_q <= credit_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            hit_q    <= hit_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = valid_q;
    assign grant_encoded = enc_q;
    assign pred_hit      = hit_q;
    assign credit        = credit_q;

endmodule
